// File: rtl/dsi_sched_pkg.sv
// Shared constants for the DSI video packet scheduler: packet data types,
// FSM state encoding and the packet header packing helper.
package dsi_sched_pkg;

  localparam logic [5:0] DT_VSS   = 6'h01;
  localparam logic [5:0] DT_VSE   = 6'h11;
  localparam logic [5:0] DT_HSS   = 6'h21;
  localparam logic [5:0] DT_HES   = 6'h31;
  localparam logic [5:0] DT_BLANK = 6'h19;
  localparam logic [5:0] DT_RGB   = 6'h3E;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_HSA_HDR,
    ST_HSA_PLD,
    ST_HES,
    ST_HBP_HDR,
    ST_HBP_PLD,
    ST_RGB_HDR,
    ST_RGB_PLD,
    ST_HFP_HDR,
    ST_HFP_PLD
  } state_t;

  // Header word: {word count or short-packet data, virtual channel 0, data type}
  function automatic logic [23:0] mk_cmd(input logic [15:0] wc, input logic [5:0] dt);
    return {wc, 2'b00, dt};
  endfunction

endpackage

// File: rtl/dsi_pld_counter.sv
// Payload beat counter: loaded with ceil(wc/4) when a long-packet header is
// accepted, counts down on each completed beat, flags the final beat.
module dsi_pld_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] wc,
  input  logic        dec,
  output logic        last
);

  logic [14:0] cnt;
  logic [14:0] beats;

  // 16-bit word count rounded up to 4-byte beats never exceeds 15 bits
  assign beats = 15'((17'(wc) + 17'd3) >> 2);

  // Down-counter; the zero guard keeps a stray handshake from wrapping it
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= beats;
    end else if (dec && (cnt != 15'd0)) begin
      cnt <= cnt - 15'd1;
    end
  end

  assign last = (cnt == 15'd1);

endmodule

// File: rtl/dsi_video_pkt_sched.sv
// DSI video-mode packet scheduler. Per line_start it emits the sync short
// packet, HSA blanking and HES; active lines add HBP, RGB and HFP long
// packets. Long packets with a zero word count are skipped at elaboration.
//
// state    | meaning
// IDLE     | waiting for line_start (enable sampled here)
// SYNC     | VSS / VSE / HSS short packet header
// HSA_HDR  | HSA blanking long-packet header
// HSA_PLD  | HSA blanking payload (zeros)
// HES      | HSync-end short packet header
// HBP_HDR  | back-porch long-packet header
// HBP_PLD  | back-porch payload (zeros)
// RGB_HDR  | pixel long-packet header
// RGB_PLD  | pixel payload, passed through from px_* combinationally
// HFP_HDR  | front-porch long-packet header
// HFP_PLD  | front-porch payload (zeros)
module dsi_video_pkt_sched
  import dsi_sched_pkg::*;
#(
  parameter logic [15:0] HSP   = 16'd6,
  parameter logic [15:0] HBP   = 16'd100,
  parameter logic [15:0] H_VAL = 16'd1080,
  parameter logic [15:0] HFP   = 16'd60,
  parameter logic [15:0] VSP   = 16'd6,
  parameter logic [15:0] VBP   = 16'd20,
  parameter logic [15:0] V_VAL = 16'd1920,
  parameter logic [15:0] VFP   = 16'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        line_start,
  output logic [23:0] pkt_cmd,
  output logic        pkt_cmd_valid,
  input  logic        pkt_cmd_ready,
  output logic [31:0] pld_data,
  output logic        pld_valid,
  output logic        pld_last,
  input  logic        pld_ready,
  input  logic [31:0] px_data,
  input  logic        px_valid,
  output logic        px_ready,
  output logic        hs_active,
  output logic        busy,
  output logic [15:0] line_cnt,
  output logic        overrun,
  input  logic        clr_err
);

  localparam logic [15:0] V_TOTAL = VSP + VBP + V_VAL + VFP;
  localparam logic [15:0] RGB_WC  = 16'(32'(H_VAL) * 32'd3);
  localparam logic [16:0] ACT_LO  = 17'(VSP) + 17'(VBP);
  localparam logic [16:0] ACT_HI  = ACT_LO + 17'(V_VAL);

  // Successor of each packet once zero-length long packets are skipped
  localparam state_t AFTER_SYNC = (HSP != 16'd0) ? ST_HSA_HDR : ST_HES;
  localparam state_t AFTER_HFP_SKIP = (HFP != 16'd0) ? ST_HFP_HDR : ST_IDLE;
  localparam state_t AFTER_HBP = (RGB_WC != 16'd0) ? ST_RGB_HDR : AFTER_HFP_SKIP;
  localparam state_t AFTER_HES = (HBP != 16'd0) ? ST_HBP_HDR : AFTER_HBP;

  state_t      state, state_nxt;
  logic        cnt_load, cnt_dec, cnt_last;
  logic [15:0] cnt_wc;
  logic [5:0]  sync_dt;
  logic        active_line;
  logic        line_done;

  dsi_pld_counter u_pld_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .wc    (cnt_wc),
    .dec   (cnt_dec),
    .last  (cnt_last)
  );

  assign active_line = ({1'b0, line_cnt} >= ACT_LO) && ({1'b0, line_cnt} < ACT_HI);
  assign sync_dt     = (line_cnt == 16'd0) ? DT_VSS :
                       (line_cnt == VSP)   ? DT_VSE : DT_HSS;
  assign busy        = (state != ST_IDLE);
  assign hs_active   = busy;
  assign line_done   = busy && (state_nxt == ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Line counter advances as each line finishes and wraps at the frame end
  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt <= '0;
    end else if (line_done) begin
      line_cnt <= (line_cnt == V_TOTAL - 16'd1) ? 16'd0 : line_cnt + 16'd1;
    end
  end

  // Sticky overrun: a line_start arriving mid-line; a new set beats a clear
  always_ff @(posedge clk) begin
    if (reset)                    overrun <= 1'b0;
    else if (line_start && busy)  overrun <= 1'b1;
    else if (clr_err)             overrun <= 1'b0;
  end

  // Next-state and output decode; headers hold until ready, beats until ready
  always_comb begin
    state_nxt     = state;
    pkt_cmd       = '0;
    pkt_cmd_valid = 1'b0;
    pld_data      = '0;
    pld_valid     = 1'b0;
    pld_last      = 1'b0;
    px_ready      = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_wc        = '0;
    case (state)
      ST_IDLE: begin
        if (line_start && enable) state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        pkt_cmd_valid = 1'b1;
        pkt_cmd       = mk_cmd(16'd0, sync_dt);
        if (pkt_cmd_ready) state_nxt = AFTER_SYNC;
      end
      ST_HSA_HDR, ST_HBP_HDR, ST_HFP_HDR, ST_RGB_HDR: begin
        pkt_cmd_valid = 1'b1;
        cnt_wc = (state == ST_HSA_HDR) ? HSP :
                 (state == ST_HBP_HDR) ? HBP :
                 (state == ST_HFP_HDR) ? HFP : RGB_WC;
        pkt_cmd = mk_cmd(cnt_wc, (state == ST_RGB_HDR) ? DT_RGB : DT_BLANK);
        if (pkt_cmd_ready) begin
          cnt_load  = 1'b1;
          state_nxt = (state == ST_HSA_HDR) ? ST_HSA_PLD :
                      (state == ST_HBP_HDR) ? ST_HBP_PLD :
                      (state == ST_HFP_HDR) ? ST_HFP_PLD : ST_RGB_PLD;
        end
      end
      ST_HSA_PLD, ST_HBP_PLD, ST_HFP_PLD: begin
        pld_valid = 1'b1;
        pld_last  = cnt_last;
        cnt_dec   = pld_ready;
        if (pld_ready && cnt_last) begin
          state_nxt = (state == ST_HSA_PLD) ? ST_HES :
                      (state == ST_HBP_PLD) ? AFTER_HBP : ST_IDLE;
        end
      end
      ST_HES: begin
        pkt_cmd_valid = 1'b1;
        pkt_cmd       = mk_cmd(16'd0, DT_HES);
        if (pkt_cmd_ready) state_nxt = active_line ? AFTER_HES : ST_IDLE;
      end
      ST_RGB_PLD: begin
        pld_data  = px_data;
        pld_valid = px_valid;
        pld_last  = cnt_last;
        px_ready  = pld_ready;
        cnt_dec   = px_valid && pld_ready;
        if (px_valid && pld_ready && cnt_last) state_nxt = AFTER_HFP_SKIP;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/dsi_video_pkt_sched.md
DSI_VIDEO_PKT_SCHED -- requirements
Module: dsi_video_pkt_sched

Interface
REQ-001 SHALL have parameters: HSP 16'd6, horizontal sync-active width in bytes; HBP 16'd100, back-porch bytes; H_VAL 16'd1080, active pixels per line; HFP 16'd60, front-porch bytes.
REQ-002 SHALL have parameters: VSP 16'd6, VBP 16'd20, V_VAL 16'd1920, VFP 16'd10, all in lines; V_TOTAL = VSP+VBP+V_VAL+VFP.
REQ-003 SHALL have ports: clk in 1, sole clock; reset in 1, synchronous active-high.
REQ-004 SHALL have ports: enable in 1, scheduling enable; line_start in 1, one-cycle line-period pulse.
REQ-005 SHALL have ports: pkt_cmd out 24, {wc_or_data[15:0], vc[1:0]=0, data_type[5:0]}; pkt_cmd_valid out 1; pkt_cmd_ready in 1.
REQ-006 SHALL have ports: pld_data out 32; pld_valid out 1; pld_last out 1; pld_ready in 1.
REQ-007 SHALL have ports: px_data in 32; px_valid in 1; px_ready out 1.
REQ-008 SHALL have ports: hs_active out 1; busy out 1; line_cnt out 16; overrun out 1, sticky; clr_err in 1.

Function
REQ-009 SHALL run FSM states IDLE, SYNC, HSA_HDR, HSA_PLD, HES, HBP_HDR, HBP_PLD, RGB_HDR, RGB_PLD, HFP_HDR, HFP_PLD.
REQ-010 SHALL leave IDLE for SYNC only on line_start with enable=1; enable is sampled only at line_start.
REQ-011 SYNC SHALL issue data_type 0x01 (VSS) when line_cnt=0, 0x11 (VSE) when line_cnt=VSP, and 0x21 (HSS) otherwise; data field = 0.
REQ-012 SHALL issue HSA, HBP and HFP as long packets with data_type 0x19 and wc equal to HSP, HBP and HFP; RGB SHALL be data_type 0x3E with wc=H_VAL*3, truncated to 16 bits.
REQ-013 SHALL issue HES as a short packet: data_type 0x31, data field 0.
REQ-014 Blanking lines SHALL send SYNC, HSA, HES, then return to IDLE.
REQ-015 Active lines (VSP+VBP <= line_cnt < VSP+VBP+V_VAL) SHALL continue through HBP, RGB and HFP before returning to IDLE.
REQ-016 pkt_cmd_valid SHALL hold, with pkt_cmd stable, until a cycle with pkt_cmd_ready=1; the FSM SHALL advance on that cycle.
REQ-017 Each long packet SHALL emit ceil(wc/4) payload beats, starting the cycle after header acceptance.
REQ-018 pld_last SHALL assert on the final beat; wc in 1..4 SHALL give a single beat with pld_last=1.
REQ-019 A beat SHALL complete only on pld_valid&pld_ready, with data held while stalled.
REQ-020 Any long packet with wc=0 SHALL be skipped entirely: no header, no payload.
REQ-021 Blanking payload SHALL be pld_data=0 with pld_valid=1.
REQ-022 In RGB_PLD: pld_data=px_data, pld_valid=px_valid, px_ready=pld_ready, combinationally; px_ready=0 in all other states.
REQ-023 line_cnt SHALL increment on returning to IDLE and wrap from V_TOTAL-1 to 0.
REQ-024 hs_active SHALL be 1 from the SYNC header until the last packet of the line is accepted, and 0 otherwise.
REQ-025 busy SHALL be 1 whenever state != IDLE.
REQ-026 line_start while busy SHALL set overrun and SHALL be otherwise ignored; the current line continues.
REQ-027 clr_err SHALL clear overrun; if clr_err and a new overrun occur in the same cycle, set wins.

Reset
REQ-028 On reset=1 at a clk edge: state IDLE; line_cnt, overrun, pkt_cmd, pkt_cmd_valid, pld_data, pld_valid, pld_last, px_ready, hs_active and busy all 0.
REQ-029 Reset mid-packet SHALL abandon the packet with no further beats; the next frame starts at VSS.

Structure
REQ-030 Package dsi_sched_pkg SHALL hold the data_type constants (0x01, 0x11, 0x21, 0x31, 0x19, 0x3E) and the FSM state encoding.
REQ-031 Sub-module dsi_pld_counter SHALL hold the beat counter: load ceil(wc/4), decrement on handshake, flag last.

Verification (HSP=2, HBP=3, H_VAL=4, HFP=5, VSP=2, VBP=1, V_VAL=2, VFP=1; V_TOTAL=6; ready tied 1)
REQ-032 line 0: line_start -> cmds 0x000001, 0x000219 with 1 beat (last, data 0), 0x000031; then IDLE, line_cnt=1.
REQ-033 line 2 -> first cmd 0x000011; line 3 -> cmds 0x000021, 0x000219, 0x000031, 0x000319 (1 beat), 0x000C3E (3 px beats, last on 3rd), 0x000519 (2 beats).
REQ-034 pkt_cmd_ready low 5 cycles on the RGB header -> header held stable; px_ready=0 until accepted.
REQ-035 Six line_starts, i.e. a full frame -> line_cnt wraps to 0; the seventh line_start issues 0x000001.
REQ-036 line_start during RGB_PLD -> overrun=1, line completes normally; clr_err -> overrun=0.
REQ-037 reset asserted during HFP_PLD -> all outputs 0 next cycle; the next line_start issues 0x000001.
